// File: rtl/axi_wlink.sv
// W-channel loopback link: a master streams sampled data_in as fixed-length bursts,
// and a slave accepts one burst per key press. Define WLINK_STATS_EN for burst_cnt/beat_err.
module axi_wlink #(
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              key,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] w_data,
    output logic              w_valid,
    output logic              w_last,
    output logic              w_ready,
    output logic [DATA_W-1:0] r_wdata,
    output logic              rx_done
`ifdef WLINK_STATS_EN
    ,
    output logic [15:0]       burst_cnt,
    output logic [0:0]        beat_err
`endif
);

    typedef enum logic [1:0] {M_IDLE, M_LOAD, M_SEND} mstate_e;
    typedef enum logic       {S_IDLE, S_RECV}         sstate_e;

    localparam logic [7:0] LAST_IDX = 8'(BURST_LEN - 1);

    mstate_e           m_state_q, m_state_d;
    sstate_e           s_state_q, s_state_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    logic              w_valid_q, w_valid_d;
    logic              w_last_q, w_last_d;
    logic [7:0]        mbeat_q, mbeat_d;
    logic              w_ready_q, w_ready_d;
    logic [DATA_W-1:0] r_wdata_q, r_wdata_d;
    logic              rx_done_q, rx_done_d;
    logic              key_q;
    logic              start;
    logic              hs;

    assign hs    = w_valid_q & w_ready_q;
    assign start = key & ~key_q;

    // ---------------- master ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_state_q <= M_IDLE;
            w_data_q  <= '0;
            w_valid_q <= 1'b0;
            w_last_q  <= 1'b0;
            mbeat_q   <= '0;
        end else begin
            m_state_q <= m_state_d;
            w_data_q  <= w_data_d;
            w_valid_q <= w_valid_d;
            w_last_q  <= w_last_d;
            mbeat_q   <= mbeat_d;
        end
    end

    always_comb begin
        m_state_d = m_state_q;
        w_data_d  = w_data_q;
        w_valid_d = w_valid_q;
        w_last_d  = w_last_q;
        mbeat_d   = mbeat_q;
        case (m_state_q)
            M_IDLE: begin
                w_valid_d = 1'b0;
                m_state_d = M_LOAD;
            end
            M_LOAD: begin
                w_data_d  = data_in;
                w_valid_d = 1'b1;
                mbeat_d   = '0;
                w_last_d  = (BURST_LEN == 1);
                m_state_d = M_SEND;
            end
            M_SEND: begin
                // Without a handshake everything holds; valid never waits on ready.
                if (hs) begin
                    if (w_last_q) begin
                        w_valid_d = 1'b0;
                        w_last_d  = 1'b0;
                        m_state_d = M_IDLE;
                    end else begin
                        mbeat_d  = mbeat_q + 8'd1;
                        w_data_d = data_in;
                        w_last_d = (mbeat_q + 8'd1 == LAST_IDX);
                    end
                end
            end
            default: m_state_d = M_IDLE;
        endcase
    end

    // ---------------- slave ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_state_q <= S_IDLE;
            w_ready_q <= 1'b0;
            r_wdata_q <= '0;
            rx_done_q <= 1'b0;
            key_q     <= 1'b0;
        end else begin
            s_state_q <= s_state_d;
            w_ready_q <= w_ready_d;
            r_wdata_q <= r_wdata_d;
            rx_done_q <= rx_done_d;
            key_q     <= key;
        end
    end

    always_comb begin
        s_state_d = s_state_q;
        w_ready_d = w_ready_q;
        r_wdata_d = r_wdata_q;
        rx_done_d = 1'b0;
        case (s_state_q)
            S_IDLE: begin
                if (start) begin
                    w_ready_d = 1'b1;
                    s_state_d = S_RECV;
                end
            end
            S_RECV: begin
                // Key edges are ignored here; only w_last ends the receive.
                if (hs) begin
                    r_wdata_d = w_data_q;
                    if (w_last_q) begin
                        w_ready_d = 1'b0;
                        rx_done_d = 1'b1;
                        s_state_d = S_IDLE;
                    end
                end
            end
            default: s_state_d = S_IDLE;
        endcase
    end

`ifdef WLINK_STATS_EN
    logic [7:0]  sbeat_q, sbeat_d;
    logic        armed_full_q, armed_full_d;
    logic [15:0] burst_cnt_q, burst_cnt_d;
    logic        beat_err_q, beat_err_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sbeat_q      <= '0;
            armed_full_q <= 1'b0;
            burst_cnt_q  <= '0;
            beat_err_q   <= 1'b0;
        end else begin
            sbeat_q      <= sbeat_d;
            armed_full_q <= armed_full_d;
            burst_cnt_q  <= burst_cnt_d;
            beat_err_q   <= beat_err_d;
        end
    end

    always_comb begin
        sbeat_d      = sbeat_q;
        armed_full_d = armed_full_q;
        burst_cnt_d  = burst_cnt_q;
        beat_err_d   = beat_err_q;
        // A length check is only meaningful if the slave saw the burst from beat 0.
        if (s_state_q == S_IDLE && start)
            armed_full_d = (m_state_q != M_SEND) || (mbeat_q == 8'd0);
        if (s_state_q == S_RECV && hs) begin
            if (w_last_q) begin
                sbeat_d = '0;
                if (armed_full_q && ({1'b0, sbeat_q} + 9'd1 != 9'(BURST_LEN)))
                    beat_err_d = 1'b1;
            end else begin
                sbeat_d = sbeat_q + 8'd1;
            end
        end
        if (rx_done_d)
            burst_cnt_d = burst_cnt_q + 16'd1;
    end

    assign burst_cnt = burst_cnt_q;
    assign beat_err  = beat_err_q;
`endif

    assign w_data  = w_data_q;
    assign w_valid = w_valid_q;
    assign w_last  = w_last_q;
    assign w_ready = w_ready_q;
    assign r_wdata = r_wdata_q;
    assign rx_done = rx_done_q;

endmodule

// File: tb/tb_axi_wlink.sv
// Self-checking bench for axi_wlink: each burst is compared against a transaction-level
// model where beat 0 is the stalled LOAD sample and beat k is data_in at beat k-1's handshake.
module tb_axi_wlink;

    localparam int DW = 32;
    localparam int BL = 4;
    localparam int NC = 24;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          key = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] w_data;
    logic          w_valid;
    logic          w_last;
    logic          w_ready;
    logic [DW-1:0] r_wdata;
    logic          rx_done;
`ifdef WLINK_STATS_EN
    logic [15:0]   burst_cnt;
    logic [0:0]    beat_err;
`endif

    int            n_chk = 0;
    int            n_fail = 0;
    bit            rnd_mode = 1'b0;
    logic [DW-1:0] stall_exp = '0;
    int            exp_bursts = 0;

    logic [DW-1:0] s_din[NC];
    logic [DW-1:0] s_data[NC];
    logic [DW-1:0] s_rdata[NC];
    logic          s_v[NC];
    logic          s_r[NC];
    logic          s_l[NC];
    logic          s_rx[NC];

    axi_wlink #(.DATA_W(DW), .BURST_LEN(BL)) dut (
        .clk(clk), .rstn(rstn), .key(key), .data_in(data_in),
        .w_data(w_data), .w_valid(w_valid), .w_last(w_last), .w_ready(w_ready),
        .r_wdata(r_wdata), .rx_done(rx_done)
`ifdef WLINK_STATS_EN
        , .burst_cnt(burst_cnt), .beat_err(beat_err)
`endif
    );

    initial forever #5 clk = ~clk;

    // Free-running source, changed well after the rising edge.
    initial forever begin
        @(posedge clk);
        #2;
        data_in = rnd_mode ? DW'($urandom) : data_in + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t required < 200000", $time);
        $fatal(1);
    end

    // Release reset at a negedge and check the IDLE -> LOAD -> SEND start-up timing.
    task automatic release_and_load(input string tag);
        logic [DW-1:0] pd;
        rstn = 1'b1;
        @(negedge clk);
        n_chk++;
        if (w_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle_cycle: w_valid=%b required 0", tag, w_valid);
        end
        pd = data_in;
        @(negedge clk);
        n_chk++;
        if (w_valid !== 1'b1 || w_data !== pd) begin
            n_fail++;
            $display("FAIL %s_load: w_valid=%b w_data=%h required 1 %h", tag, w_valid, w_data, pd);
        end
        stall_exp = pd;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++;
            if ({w_valid, w_ready, w_last, rx_done} !== 4'b0000 || w_data !== '0 || r_wdata !== '0) begin
                n_fail++;
                $display("FAIL reset_state: v/r/l/rx=%b%b%b%b w_data=%h r_wdata=%h required all 0",
                         w_valid, w_ready, w_last, rx_done, w_data, r_wdata);
            end
`ifdef WLINK_STATS_EN
            n_chk++;
            if (burst_cnt !== 16'd0 || beat_err !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_stats: burst_cnt=%0d beat_err=%b required 0 0", burst_cnt, beat_err);
            end
`endif
        end
        release_and_load("reset");
    endtask

    task automatic test_idle_stall();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_chk++;
            if (w_data !== stall_exp) begin
                n_fail++;
                $display("FAIL stall_data[%0d]: w_data=%h required %h", i, w_data, stall_exp);
            end
            n_chk++;
            if ({w_valid, w_ready, w_last} !== {1'b1, 1'b0, 1'(BL == 1)} || r_wdata !== '0) begin
                n_fail++;
                $display("FAIL stall_ctrl[%0d]: v/r/l=%b%b%b r_wdata=%h required 1 0 %b 0",
                         i, w_valid, w_ready, w_last, r_wdata, 1'(BL == 1));
            end
        end
    endtask

    // One key press (held key_cyc cycles) and the resulting burst, checked against the model.
    task automatic test_burst(input string tag, input int key_cyc, input bit rnd);
        int            hs[$];
        logic [DW-1:0] exp_b[BL];
        int            nrx;
        int            rx_at;
        int            j;
        rnd_mode = rnd;
        for (int i = 0; i < NC; i++) begin
            @(negedge clk);
            s_din[i]   = data_in;
            s_data[i]  = w_data;
            s_rdata[i] = r_wdata;
            s_v[i]     = w_valid;
            s_r[i]     = w_ready;
            s_l[i]     = w_last;
            s_rx[i]    = rx_done;
            key        = (i < key_cyc);
        end
        key = 1'b0;
        rnd_mode = 1'b0;

        for (int i = 0; i < NC; i++)
            if (s_v[i] === 1'b1 && s_r[i] === 1'b1) hs.push_back(i);
        n_chk++;
        if (hs.size() != BL) begin
            n_fail++;
            $display("FAIL %s_beats: handshakes=%0d required %0d", tag, hs.size(), BL);
        end
        for (int k = 0; k < hs.size() && k < BL; k++) begin
            exp_b[k] = (k == 0) ? stall_exp : s_din[hs[k-1]];
            n_chk++;
            if (s_data[hs[k]] !== exp_b[k] || s_l[hs[k]] !== (k == BL - 1)) begin
                n_fail++;
                $display("FAIL %s_beat%0d: w_data=%h w_last=%b required %h %b",
                         tag, k, s_data[hs[k]], s_l[hs[k]], exp_b[k], (k == BL - 1));
            end
        end

        nrx = 0;
        rx_at = -1;
        for (int i = 0; i < NC; i++)
            if (s_rx[i] === 1'b1) begin
                nrx++;
                if (rx_at < 0) rx_at = i;
            end
        n_chk++;
        if (nrx != 1) begin
            n_fail++;
            $display("FAIL %s_rx_count: rx_done pulses=%0d required 1", tag, nrx);
        end
        n_chk++;
        if (s_r[NC-1] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_ready_after: w_ready=%b required 0", tag, s_r[NC-1]);
        end

        if (hs.size() == BL) begin
            j = hs[BL-1];
            n_chk++;
            if (rx_at != j + 1) begin
                n_fail++;
                $display("FAIL %s_rx_timing: rx_done at cycle %0d required %0d", tag, rx_at, j + 1);
            end
            n_chk++;
            if (s_rdata[j+1] !== exp_b[BL-1]) begin
                n_fail++;
                $display("FAIL %s_r_wdata: r_wdata=%h required %h", tag, s_rdata[j+1], exp_b[BL-1]);
            end
            if (j + 3 < NC) begin
                n_chk++;
                if ({s_v[j+1], s_v[j+2], s_v[j+3]} !== 3'b001 || s_data[j+3] !== s_din[j+2]) begin
                    n_fail++;
                    $display("FAIL %s_reload: valid seq=%b%b%b w_data=%h required 001 %h",
                             tag, s_v[j+1], s_v[j+2], s_v[j+3], s_data[j+3], s_din[j+2]);
                end
                stall_exp = s_din[j+2];
            end
        end
        exp_bursts++;
`ifdef WLINK_STATS_EN
        n_chk++;
        if (burst_cnt !== 16'(exp_bursts) || beat_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_stats: burst_cnt=%0d beat_err=%b required %0d 0",
                     tag, burst_cnt, beat_err, exp_bursts);
        end
`endif
    endtask

    task automatic test_reset_mid_burst();
        int nhs = 0;
        for (int i = 0; i < 20 && nhs < 2; i++) begin
            @(negedge clk);
            if (w_valid === 1'b1 && w_ready === 1'b1) nhs++;
            key = (i == 0);
        end
        key = 1'b0;
        n_chk++;
        if (nhs != 2) begin
            n_fail++;
            $display("FAIL midrst_beats: handshakes before reset=%0d required 2", nhs);
        end
        @(negedge clk);
        rstn = 1'b0;
        #1;
        n_chk++;
        if ({w_valid, w_ready, w_last, rx_done} !== 4'b0000 || r_wdata !== '0 || w_data !== '0) begin
            n_fail++;
            $display("FAIL midrst_abort: v/r/l/rx=%b%b%b%b r_wdata=%h w_data=%h required all 0",
                     w_valid, w_ready, w_last, rx_done, r_wdata, w_data);
        end
        exp_bursts = 0;
        repeat (2) @(negedge clk);
`ifdef WLINK_STATS_EN
        n_chk++;
        if (burst_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL midrst_stats: burst_cnt=%0d required 0", burst_cnt);
        end
`endif
        release_and_load("midrst");
        repeat (3) @(negedge clk);
        test_burst("post_reset", 1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_idle_stall();
        test_burst("single", 1, 1'b0);
        test_burst("second", 1, 1'b1);
        test_burst("key_held", 10, 1'b0);
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_wlink.md
Name: axi_wlink

Overview:
- Self-contained AXI4-style write-data (W) channel link, used as a loopback/bring-up block.
- Master half: samples a free-running data source (data_in) and offers fixed-length bursts on the W channel.
- Slave half: accepts exactly one burst per start request (key) and registers the received beats.
- W-channel signals are exported for observation. No AW/B/AR/R channels.

Parameters:
- DATA_W, 32, W-channel data width.
- BURST_LEN, 4, beats per burst (allowed range 1..256).

Ports:
- clk  in  1  clock (already decided).
- rstn  in  1  asynchronous active-low reset (already decided).
- key  in  1  synchronous start request; a rising edge arms the slave for one burst.
- data_in  in  DATA_W  source data, sampled by the master.
- w_data  out  DATA_W  WDATA driven by the master.
- w_valid  out  1  WVALID.
- w_last  out  1  WLAST.
- w_ready  out  1  WREADY driven by the slave.
- r_wdata  out  DATA_W  last data word accepted by the slave.
- rx_done  out  1  one-cycle pulse after the final beat of a burst is accepted.

Behaviour:
- All state elements reset asynchronously on rstn=0.
- Reset values: w_data=0, w_valid=0, w_last=0, w_ready=0, r_wdata=0, rx_done=0, beat counters=0, both FSMs in IDLE.
- Handshake: a beat transfers on a rising clk edge when w_valid=1 and w_ready=1.
- Master FSM, states IDLE -> LOAD -> SEND -> IDLE:
  - IDLE lasts one cycle, w_valid=0, then goes to LOAD.
  - LOAD: w_data<=data_in, w_valid<=1, mbeat<=0, w_last<=(BURST_LEN==1); go to SEND.
  - SEND, no handshake: w_data, w_valid and w_last hold stable. w_valid never depends on w_ready.
  - SEND, handshake with w_last=0: mbeat+1, w_data<=data_in (current sample), w_last<=(mbeat+1==BURST_LEN-1).
  - SEND, handshake with w_last=1: w_valid<=0, w_last<=0, go to IDLE. This gives at least one idle cycle between bursts.
- Slave FSM, states IDLE -> RECV -> IDLE:
  - key_d is key registered one cycle; start = key & ~key_d.
  - IDLE: on start, w_ready<=1 and go to RECV.
  - RECV, on each handshake: r_wdata<=w_data and sbeat+1.
  - RECV, handshake with w_last=1: w_ready<=0, rx_done<=1 for one cycle, sbeat<=0, return to IDLE.
  - start events while in RECV are ignored.
- Slave arming mid-burst: if w_ready rises while the master is part-way through a burst, the slave accepts the remaining beats up to and including w_last, then completes. A partial burst is legal.
- Outside RECV, w_ready=0, so the master stalls indefinitely in SEND holding its beat.
- Counters: mbeat/sbeat are 8 bits. sbeat is used only by the optional feature and wraps modulo 256.
- Reset asserted mid-burst aborts everything immediately. After release the master restarts from IDLE.

Optional Feature:
- Macro WLINK_STATS_EN.
- Defined:
  - adds output burst_cnt[15:0]: increments on each rx_done pulse, wraps at 0xFFFF->0, resets to 0.
  - adds output beat_err[0:0]: sticky flag, set when w_last is accepted with sbeat+1 != BURST_LEN while the slave was armed before the master's first beat; cleared only by reset.
- Undefined: neither port exists and no related logic is present.

Test Plan:
- Reset: hold rstn=0 for 30 ns with data_in counting -> all outputs 0, w_valid stays 0 during reset.
- Idle stall: after reset with key=0 and data_in incrementing each cycle -> w_valid=1, w_data frozen at its LOAD sample, w_ready=0, r_wdata=0 for at least 20 cycles.
- Single burst:
  - stimulus: pulse key for one cycle, BURST_LEN=4.
  - w_ready high for exactly 4 handshakes; w_last high on the 4th.
  - r_wdata equals the 4th beat's w_data; rx_done pulses once; w_ready=0 afterwards.
  - beat 1 is the stalled value; beats 2-4 are consecutive data_in samples each +1.
- Key held high for 10 cycles -> only one burst received and only one rx_done pulse.
- Second key after rx_done -> new burst accepted; r_wdata updates to that burst's 4th beat; with WLINK_STATS_EN, burst_cnt=2.
- Reset asserted mid-burst after 2 beats -> w_valid=0, w_ready=0, r_wdata=0 immediately. After release, the next key yields a full 4-beat burst.
